// File: rtl/fsm_sort.sv
// Sequential bubble-sort engine: loads N unsigned elements on start and performs one
// compare/swap per clock, raising done when data_sorted holds the ascending result.
module fsm_sort #(
    parameter int N     = 6,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in [N],
    output logic             done,
    output logic [WIDTH-1:0] data_sorted [N]
);
    localparam int CW = $clog2(N);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SORT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_reg;
    logic             done_reg;
    logic [CW-1:0]    i_reg;
    logic [CW-1:0]    j_reg;
    logic [CW-1:0]    j_hi;
    logic [WIDTH-1:0] arr_reg  [N];
    logic [WIDTH-1:0] arr_next [N];
    logic             swap;
    logic             last_j;
    logic             last_i;

    assign j_hi = j_reg + CW'(1);
    // Strict compare keeps equal elements in their original order.
    assign swap   = arr_reg[j_reg] > arr_reg[j_hi];
    assign last_j = j_reg >= (CW'(N - 2) - i_reg);
    assign last_i = i_reg >= CW'(N - 2);

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_elem
            assign arr_next[gi] = (swap && (j_reg == CW'(gi))) ? arr_reg[j_hi]  :
                                  (swap && (j_hi  == CW'(gi))) ? arr_reg[j_reg] :
                                                                 arr_reg[gi];
            assign data_sorted[gi] = arr_reg[gi];
        end
    endgenerate

    assign done = done_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            done_reg  <= 1'b0;
            i_reg     <= '0;
            j_reg     <= '0;
            for (int k = 0; k < N; k++) begin
                arr_reg[k] <= '0;
            end
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        arr_reg   <= data_in;
                        i_reg     <= '0;
                        j_reg     <= '0;
                        done_reg  <= 1'b0;
                        state_reg <= ST_SORT;
                    end
                end
                ST_SORT: begin
                    arr_reg <= arr_next;
                    if (!last_j) begin
                        j_reg <= j_reg + CW'(1);
                    end else if (!last_i) begin
                        i_reg <= i_reg + CW'(1);
                        j_reg <= '0;
                    end else begin
                        state_reg <= ST_DONE;
                        done_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fsm_sort.sv
// Scenario-driven bench for fsm_sort: expected sorted vectors are queued at each
// accepted start and compared, together with the 15-edge latency, when done rises.
module tb_fsm_sort;
    localparam int N   = 6;
    localparam int W   = 8;
    localparam int LAT = N * (N - 1) / 2;

    typedef logic [N*W-1:0] vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] data_in     [N];
    logic         done;
    logic [W-1:0] data_sorted [N];

    int   total = 0;
    int   bad   = 0;
    vec_t sb[$];

    fsm_sort #(.N(N), .WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .data_in    (data_in),
        .done       (done),
        .data_sorted(data_sorted)
    );

    always #5 clk = ~clk;

    // Element 0 sits in the low bits.
    function automatic vec_t mk(input int a0, a1, a2, a3, a4, a5);
        return {W'(a5), W'(a4), W'(a3), W'(a2), W'(a1), W'(a0)};
    endfunction

    function automatic vec_t dut_out();
        vec_t r;
        for (int k = 0; k < N; k++) r[k*W +: W] = data_sorted[k];
        return r;
    endfunction

    // Counting sort, independent of the bubble-sort datapath.
    function automatic vec_t ref_sort(input vec_t v);
        int   cnt [256];
        int   p;
        vec_t r;
        for (int k = 0; k < 256; k++) cnt[k] = 0;
        for (int k = 0; k < N; k++) cnt[v[k*W +: W]]++;
        p = 0;
        for (int x = 0; x < 256; x++) begin
            for (int c = 0; c < cnt[x]; c++) begin
                r[p*W +: W] = W'(x);
                p++;
            end
        end
        return r;
    endfunction

    // Drives one accepted start; returns at the negedge after the accepting edge.
    task automatic accept(input vec_t v, input vec_t exp);
        @(negedge clk);
        for (int k = 0; k < N; k++) data_in[k] = v[k*W +: W];
        start = 1'b1;
        sb.push_back(exp);
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < N; k++) data_in[k] = W'($urandom);
    endtask

    // Counts edges until done is seen, bounded so a stuck DUT cannot hang the run.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        vec_t got;
        rst   = 1'b1;
        start = 1'b0;
        for (int k = 0; k < N; k++) data_in[k] = '0;
        repeat (2) @(negedge clk);
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL reset_done got=%b want=0", done);
        end
        got = dut_out();
        total++;
        if (got !== '0) begin
            bad++;
            $display("FAIL reset_data got=%h want=0", got);
        end
        rst = 1'b0;
        @(negedge clk);
        $display("reset checked: done=%b data=%h", done, got);
    endtask

    task automatic test_basic(input string name, input vec_t v, input vec_t exp);
        int   lat;
        vec_t want;
        vec_t got;
        accept(v, exp);
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL %s_done_at_accept got=%b want=0", name, done);
        end
        wait_done(lat);
        total++;
        if (lat != LAT) begin
            bad++;
            $display("FAIL %s_latency got=%0d want=%0d", name, lat, LAT);
        end
        want = sb.pop_front();
        got  = dut_out();
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s_data got=%h want=%h", name, got, want);
        end
        $display("%s: in=%h out=%h lat=%0d", name, v, got, lat);
    endtask

    task automatic test_patterns();
        vec_t ins  [4];
        vec_t outs [4];
        ins[0] = mk(3, 2, 4, 0, 1, 5);        outs[0] = mk(0, 1, 2, 3, 4, 5);
        ins[1] = mk(1, 1, 1, 0, 2, 0);        outs[1] = mk(0, 0, 1, 1, 1, 2);
        ins[2] = mk(0, 1, 2, 3, 4, 5);        outs[2] = mk(0, 1, 2, 3, 4, 5);
        ins[3] = mk(255, 200, 7, 7, 1, 0);    outs[3] = mk(0, 1, 7, 7, 200, 255);
        for (int t = 0; t < 4; t++) test_basic($sformatf("pattern%0d", t), ins[t], outs[t]);
    endtask

    task automatic test_random();
        vec_t v;
        for (int t = 0; t < 4; t++) begin
            for (int k = 0; k < N; k++) v[k*W +: W] = W'($urandom);
            test_basic($sformatf("random%0d", t), v, ref_sort(v));
        end
    endtask

    task automatic test_start_ignored();
        int   lat;
        vec_t want;
        vec_t got;
        accept(mk(9, 8, 7, 6, 5, 4), mk(4, 5, 6, 7, 8, 9));
        repeat (5) @(negedge clk);
        for (int k = 0; k < N; k++) data_in[k] = W'(k * 40 + 1);
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        lat = lat + 8;
        total++;
        if (lat != LAT) begin
            bad++;
            $display("FAIL ignored_latency got=%0d want=%0d", lat, LAT);
        end
        want = sb.pop_front();
        got  = dut_out();
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL ignored_data got=%h want=%h", got, want);
        end
        $display("start_ignored: out=%h lat=%0d", got, lat);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            total++;
            if (done !== 1'b1 || dut_out() !== want) begin
                bad++;
                $display("FAIL hold_cycle%0d done=%b data=%h want done=1 data=%h",
                         c, done, dut_out(), want);
            end
        end
        $display("hold: 10 idle cycles in DONE, done=%b data=%h", done, dut_out());
    endtask

    task automatic test_reset_mid();
        vec_t got;
        accept(mk(50, 40, 30, 20, 10, 0), mk(0, 10, 20, 30, 40, 50));
        void'(sb.pop_back());
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL midreset_done got=%b want=0", done);
        end
        got = dut_out();
        total++;
        if (got !== '0) begin
            bad++;
            $display("FAIL midreset_data got=%h want=0", got);
        end
        $display("reset_mid: done=%b data=%h", done, got);
        repeat (3) @(negedge clk);
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL midreset_idle_done got=%b want=0", done);
        end
        test_basic("after_reset", mk(6, 250, 3, 3, 128, 0), mk(0, 3, 3, 6, 128, 250));
    endtask

    initial begin
        test_reset();
        test_basic("first", mk(5, 0, 2, 1, 1, 3), mk(0, 1, 1, 2, 3, 5));
        test_basic("back_to_back", mk(3, 2, 4, 0, 1, 5), mk(0, 1, 2, 3, 4, 5));
        test_patterns();
        test_start_ignored();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
